// File: rtl/fwrisc_csr_rmw_pkg.sv
// Shared definitions for the CSR read-modify-write block: op encoding, FSM states
// and the regfile-space CSR address map (CSRs live at indices 32-63).
package fwrisc_csr_rmw_pkg;

  typedef enum logic [1:0] {
    OpIllegal = 2'b00,
    OpRw      = 2'b01,
    OpRs      = 2'b10,
    OpRc      = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StExec,
    StWb
  } rmw_state_e;

  localparam logic [5:0] CsrMstatus   = 6'h20;
  localparam logic [5:0] CsrMisa      = 6'h21;
  localparam logic [5:0] CsrMie       = 6'h22;
  localparam logic [5:0] CsrMtvec     = 6'h23;
  localparam logic [5:0] CsrMscratch  = 6'h24;
  localparam logic [5:0] CsrMepc      = 6'h25;
  localparam logic [5:0] CsrMcause    = 6'h26;
  localparam logic [5:0] CsrMtval     = 6'h27;
  localparam logic [5:0] CsrMip       = 6'h28;
  localparam logic [5:0] CsrMcycle    = 6'h29;
  localparam logic [5:0] CsrMinstret  = 6'h2A;
  localparam logic [5:0] CsrMcycleh   = 6'h2B;
  localparam logic [5:0] CsrMinstreth = 6'h2C;
  localparam logic [5:0] CsrMvendorid = 6'h2D;
  localparam logic [5:0] CsrMarchid   = 6'h2E;
  localparam logic [5:0] CsrMimpid    = 6'h2F;
  localparam logic [5:0] CsrMhartid   = 6'h30;

  function automatic logic csr_is_read_only(input logic [5:0] csr);
    return (csr == CsrMvendorid) || (csr == CsrMarchid) || (csr == CsrMimpid) ||
           (csr == CsrMhartid)   || (csr == CsrMisa)    || (csr == CsrMip);
  endfunction

endpackage

// File: rtl/fwrisc_csr_rmw.sv
// CSRRW/CSRRS/CSRRC sequencer: reads GPR and CSR from the shared regfile, writes the
// new CSR value in EXEC and the old value to rd in WB. Fixed 3-cycle latency.
module fwrisc_csr_rmw
  import fwrisc_csr_rmw_pkg::*;
#(
  parameter int unsigned RV32E = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_use_imm,
  input  logic [5:0]  req_csr,
  input  logic [5:0]  req_rs1,
  input  logic [4:0]  req_uimm,
  input  logic [5:0]  req_rd,
  output logic [5:0]  ra_raddr,
  input  logic [31:0] ra_rdata,
  output logic [5:0]  rb_raddr,
  input  logic [31:0] rb_rdata,
  output logic [5:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        rd_wen,
  output logic        done,
  output logic        illegal
);

  rmw_state_e  state_q;
  csr_op_e     op_q;
  logic        use_imm_q;
  logic [5:0]  csr_q;
  logic [5:0]  rs1_q;
  logic [4:0]  uimm_q;
  logic [5:0]  rd_q;
  logic        illegal_q;
  logic [31:0] old_q;

  logic [31:0] operand;
  logic [31:0] new_val;
  logic        wr_suppress;

  // Set/clear with a zero operand is a pure read and must not trip read-only checks.
  function automatic logic write_suppressed(input csr_op_e op, input logic use_imm,
                                            input logic [5:0] rs1, input logic [4:0] uimm);
    return (op != OpRw) && (use_imm ? (uimm == 5'd0) : (rs1 == 6'd0));
  endfunction

  function automatic logic req_is_illegal(input csr_op_e op, input logic use_imm,
                                          input logic [5:0] csr, input logic [5:0] rs1,
                                          input logic [4:0] uimm, input logic [5:0] rd);
    logic wr;
    logic e_viol;
    wr     = !write_suppressed(op, use_imm, rs1, uimm);
    e_viol = (RV32E != 0) && (((!use_imm) && (rs1[5:4] == 2'b01)) || (rd[5:4] == 2'b01));
    return (op == OpIllegal) || !csr[5] || (wr && csr_is_read_only(csr)) || e_viol;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= OpIllegal;
      use_imm_q <= 1'b0;
      csr_q     <= '0;
      rs1_q     <= '0;
      uimm_q    <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      old_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q      <= csr_op_e'(req_op);
            use_imm_q <= req_use_imm;
            csr_q     <= req_csr;
            rs1_q     <= req_rs1;
            uimm_q    <= req_uimm;
            rd_q      <= req_rd;
            illegal_q <= req_is_illegal(csr_op_e'(req_op), req_use_imm, req_csr, req_rs1,
                                        req_uimm, req_rd);
            state_q   <= StRead;
          end
        end
        StRead: state_q <= StExec;
        StExec: begin
          old_q   <= rb_rdata;
          state_q <= StWb;
        end
        StWb: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    operand     = use_imm_q ? {27'b0, uimm_q} : ra_rdata;
    wr_suppress = write_suppressed(op_q, use_imm_q, rs1_q, uimm_q);
    unique case (op_q)
      OpRw:    new_val = operand;
      OpRs:    new_val = rb_rdata | operand;
      OpRc:    new_val = rb_rdata & ~operand;
      default: new_val = rb_rdata;
    endcase
  end

  // Outputs decode straight from the state register so reset clears them next cycle.
  always_comb begin
    req_ready = 1'b0;
    ra_raddr  = '0;
    rb_raddr  = '0;
    rd_waddr  = '0;
    rd_wdata  = '0;
    rd_wen    = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StRead: begin
        ra_raddr = use_imm_q ? 6'd0 : rs1_q;
        rb_raddr = csr_q;
      end
      StExec: begin
        if (!illegal_q && !wr_suppress) begin
          rd_wen   = 1'b1;
          rd_waddr = csr_q;
          rd_wdata = new_val;
        end
      end
      StWb: begin
        done    = 1'b1;
        illegal = illegal_q;
        if (!illegal_q && (rd_q != 6'd0)) begin
          rd_wen   = 1'b1;
          rd_waddr = rd_q;
          rd_wdata = old_q;
        end
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fwrisc_csr_rmw.sv
// Directed bench for fwrisc_csr_rmw with a behavioural registered-read regfile.
module tb_fwrisc_csr_rmw;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_use_imm;
  logic [5:0]  req_csr;
  logic [5:0]  req_rs1;
  logic [4:0]  req_uimm;
  logic [5:0]  req_rd;
  logic [5:0]  ra_raddr;
  logic [31:0] ra_rdata;
  logic [5:0]  rb_raddr;
  logic [31:0] rb_rdata;
  logic [5:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        rd_wen;
  logic        done;
  logic        illegal;

  logic [31:0] regs [64];
  logic        pl_en;
  logic [5:0]  pl_addr;
  logic [31:0] pl_data;

  int vecs = 0;
  int errs = 0;

  // Per-phase captures from the last transaction
  logic [31:0] r_ra, r_rb, r_wen, r_rdy;
  logic [31:0] e_wen, e_waddr, e_wdata, e_done;
  logic [31:0] w_wen, w_waddr, w_wdata, w_done, w_ill;
  int          waits;
  logic        saw_done;

  always #5 clock = ~clock;

  fwrisc_csr_rmw #(.RV32E(0)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_use_imm (req_use_imm),
    .req_csr     (req_csr),
    .req_rs1     (req_rs1),
    .req_uimm    (req_uimm),
    .req_rd      (req_rd),
    .ra_raddr    (ra_raddr),
    .ra_rdata    (ra_rdata),
    .rb_raddr    (rb_raddr),
    .rb_rdata    (rb_rdata),
    .rd_waddr    (rd_waddr),
    .rd_wdata    (rd_wdata),
    .rd_wen      (rd_wen),
    .done        (done),
    .illegal     (illegal)
  );

  always @(posedge clock) begin
    ra_rdata <= regs[ra_raddr];
    rb_rdata <= regs[rb_raddr];
    if (rd_wen) regs[rd_waddr] <= rd_wdata;
    if (pl_en) regs[pl_addr] <= pl_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clock);
    pl_en   = 1'b0;
  endtask

  // Called at a negedge; returns at the WB-phase negedge.
  task automatic do_op(input logic [1:0] op, input logic imm, input logic [5:0] csr,
                       input logic [5:0] rs1, input logic [4:0] uimm, input logic [5:0] rd);
    req_valid   = 1'b1;
    req_op      = op;
    req_use_imm = imm;
    req_csr     = csr;
    req_rs1     = rs1;
    req_uimm    = uimm;
    req_rd      = rd;
    waits       = 0;
    while (!req_ready && waits < 10) begin
      @(negedge clock);
      waits++;
    end
    if (!req_ready) begin
      errs++;
      $display("FAIL accept_timeout: observed req_ready=0 expected 1");
    end
    @(negedge clock);
    req_valid = 1'b0;
    r_ra = 32'(ra_raddr); r_rb = 32'(rb_raddr); r_wen = 32'(rd_wen); r_rdy = 32'(req_ready);
    @(negedge clock);
    e_wen = 32'(rd_wen); e_waddr = 32'(rd_waddr); e_wdata = rd_wdata; e_done = 32'(done);
    @(negedge clock);
    w_wen = 32'(rd_wen); w_waddr = 32'(rd_waddr); w_wdata = rd_wdata;
    w_done = 32'(done); w_ill = 32'(illegal);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_use_imm = 1'b0; req_csr = '0;
    req_rs1 = '0; req_uimm = '0; req_rd = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_wen", 32'(rd_wen), 32'd0);
    chk("rst_outs", {8'd0, ra_raddr, rb_raddr, rd_waddr, 6'd0}, 32'd0);
    chk("rst_wdata", rd_wdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 64; i++) preload(6'(i), 32'd0);
    preload(6'h24, 32'h11);
    preload(6'd5,  32'hA5A5A5A5);
    preload(6'h23, 32'h100);
    preload(6'h29, 32'h1234);
    preload(6'd2,  32'h0000DEAD);

    // CSRRW MSCRATCH, rs1=x5, rd=x6
    do_op(2'b01, 1'b0, 6'h24, 6'd5, 5'd0, 6'd6);
    chk("rw_read_ra", r_ra, 32'd5);
    chk("rw_read_rb", r_rb, 32'h24);
    chk("rw_read_ready", r_rdy, 32'd0);
    chk("rw_read_wen", r_wen, 32'd0);
    chk("rw_exec_wen", e_wen, 32'd1);
    chk("rw_exec_waddr", e_waddr, 32'h24);
    chk("rw_exec_wdata", e_wdata, 32'hA5A5A5A5);
    chk("rw_exec_done", e_done, 32'd0);
    chk("rw_wb_wen", w_wen, 32'd1);
    chk("rw_wb_waddr", w_waddr, 32'd6);
    chk("rw_wb_wdata", w_wdata, 32'h11);
    chk("rw_wb_done", w_done, 32'd1);
    chk("rw_wb_ill", w_ill, 32'd0);

    // CSRRSI MTVEC, uimm=3, rd=x1, then CSRRCI uimm=1
    do_op(2'b10, 1'b1, 6'h23, 6'd9, 5'd3, 6'd1);
    chk("rsi_read_ra", r_ra, 32'd0);
    chk("rsi_exec_waddr", e_waddr, 32'h23);
    chk("rsi_exec_wdata", e_wdata, 32'h103);
    chk("rsi_wb_waddr", w_waddr, 32'd1);
    chk("rsi_wb_wdata", w_wdata, 32'h100);
    do_op(2'b11, 1'b1, 6'h23, 6'd0, 5'd1, 6'd1);
    chk("rci_exec_wen", e_wen, 32'd1);
    chk("rci_exec_wdata", e_wdata, 32'h102);
    chk("rci_wb_wdata", w_wdata, 32'h103);

    // CSRRS MCYCLE with rs1=x0 is a pure read
    do_op(2'b10, 1'b0, 6'h29, 6'd0, 5'd0, 6'd7);
    chk("rs_x0_exec_wen", e_wen, 32'd0);
    chk("rs_x0_wb_wen", w_wen, 32'd1);
    chk("rs_x0_wb_waddr", w_waddr, 32'd7);
    chk("rs_x0_wb_wdata", w_wdata, 32'h1234);
    chk("rs_x0_wb_ill", w_ill, 32'd0);

    // Read-only RO write, op=00, csr outside CSR space
    do_op(2'b01, 1'b0, 6'h30, 6'd2, 5'd0, 6'd3);
    chk("ro_exec_wen", e_wen, 32'd0);
    chk("ro_wb_wen", w_wen, 32'd0);
    chk("ro_wb_done", w_done, 32'd1);
    chk("ro_wb_ill", w_ill, 32'd1);
    do_op(2'b00, 1'b0, 6'h24, 6'd5, 5'd0, 6'd6);
    chk("op0_wen", e_wen | w_wen, 32'd0);
    chk("op0_done_ill", {w_done[15:0], w_ill[15:0]}, 32'h00010001);
    do_op(2'b01, 1'b0, 6'h05, 6'd2, 5'd0, 6'd3);
    chk("csr05_wen", e_wen | w_wen, 32'd0);
    chk("csr05_done_ill", {w_done[15:0], w_ill[15:0]}, 32'h00010001);
    chk("illegal_no_side_effect", regs[6'h24], 32'hA5A5A5A5);

    // CSRRW rd=x0, then a back-to-back request held over WB
    do_op(2'b01, 1'b0, 6'h24, 6'd2, 5'd0, 6'd0);
    chk("rd0_exec_wen", e_wen, 32'd1);
    chk("rd0_exec_wdata", e_wdata, 32'h0000DEAD);
    chk("rd0_wb_wen", w_wen, 32'd0);
    chk("rd0_wb_done", w_done, 32'd1);
    do_op(2'b10, 1'b1, 6'h23, 6'd0, 5'd4, 6'd8);
    chk("b2b_waits", 32'(waits), 32'd1);
    chk("b2b_exec_wdata", e_wdata, 32'h106);
    chk("b2b_wb_wdata", w_wdata, 32'h102);
    chk("b2b_wb_waddr", w_waddr, 32'd8);

    // Reset while in EXEC
    @(negedge clock);
    req_valid = 1'b1; req_op = 2'b01; req_use_imm = 1'b0; req_csr = 6'h24;
    req_rs1 = 6'd5; req_uimm = 5'd0; req_rd = 6'd6;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    chk("rstx_in_exec", 32'(rd_wen), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("rstx_wen", 32'(rd_wen), 32'd0);
    chk("rstx_ready", 32'(req_ready), 32'd1);
    chk("rstx_done", 32'(done), 32'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clock);
      saw_done = saw_done | done | rd_wen;
    end
    chk("rstx_no_late_done", 32'(saw_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
